// File: rtl/aes_loader_pkg.sv
// Shared types and geometry for the AES state loader.
// Column-major state layout: state[col][row] holds byte index col*NB + row.
package aes_loader_pkg;

   localparam int NB     = 4;
   localparam int NC     = 4;
   localparam int NBYTES = NB * NC;
   localparam int CNT_W  = $clog2(NBYTES);
   localparam int ROW_W  = $clog2(NB);
   localparam int COL_W  = $clog2(NC);

   typedef logic [7:0] byte_t;
   typedef byte_t [NB-1:0] col_t;
   typedef byte_t [NC-1:0][NB-1:0] state_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      FULL
   } ldr_fsm_t;

   // One-hot column strobe for a column index.
   function automatic logic [NC-1:0] col_onehot(input logic [COL_W-1:0] col);
      logic [NC-1:0] oh;
      oh      = '0;
      oh[col] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mod_ldr_col.sv
// One NB-byte column register of the state loader.
// Priority: reset, clear, whole-column load, single-byte write.
module mod_ldr_col
   import aes_loader_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] row,
   input  logic [7:0]       din,
   input  logic             load,
   input  col_t             load_data,
   output col_t             col
);

   // Column storage: byte write at the row index, or full-column copy.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         col <= '0;
      end else if (clear) begin
         col <= '0;
      end else if (load) begin
         col <= load_data;
      end else if (wr_en) begin
         col[row] <= din;
      end
   end

endmodule

// File: rtl/mod_state_loader_ctrl.sv
// Byte-serial to 128-bit state loader for the AES-256 core.
// Bytes arrive over a valid/ready handshake and are steered column-major
// into out_state; the finished block is offered over a second handshake.
// Optional macro LOADER_DBLBUF_EN adds a fill bank in front of out_state so
// a new block can be assembled while the previous one waits for its consumer.
//
// state | meaning
// IDLE  | no bytes of the current block held, byte_cnt = 0
// FILL  | partial block held, accepting bytes
// FULL  | complete block waiting; no bytes accepted
//       |   (default: block is in out_state; dblbuf: block is in the bank)
module mod_state_loader_ctrl
   import aes_loader_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_byte,
   output logic [NC-1:0]    col_wr_en,
   output logic [CNT_W-1:0] byte_cnt,
   output logic             out_valid,
   input  logic             out_ready,
   output state_t           out_state
);

   ldr_fsm_t         state;
   logic             wr;
   logic             last;
   logic [ROW_W-1:0] wr_row;
   logic [COL_W-1:0] wr_col;

   assign in_ready = (state != FULL);
   // Flush discards a byte offered in the same cycle.
   assign wr       = in_valid & in_ready & ~flush;
   assign last     = (byte_cnt == CNT_W'(NBYTES - 1));
   assign wr_row   = byte_cnt[ROW_W-1:0];
   assign wr_col   = byte_cnt[CNT_W-1:ROW_W];

   // Column strobe decoded from the slot index for the byte accepted now.
   always_comb begin
      col_wr_en = '0;
      if (wr) begin
         col_wr_en = col_onehot(wr_col);
      end
   end

`ifdef LOADER_DBLBUF_EN
   state_t bank;
   state_t load_blk;
   logic   xfer;

   // Bank contents including the byte being written this cycle, so the
   // completing edge can copy the whole block in one step.
   always_comb begin
      load_blk = bank;
      if (wr) begin
         load_blk[wr_col][wr_row] = in_byte;
      end
   end

   assign xfer = ~flush & ((wr & last & (~out_valid | out_ready)) |
                           ((state == FULL) & out_ready));

   for (genvar c = 0; c < NC; c++) begin : g_col
      mod_ldr_col u_bank (
         .clk       (clk),
         .resetn    (resetn),
         .clear     (flush),
         .wr_en     (col_wr_en[c]),
         .row       (wr_row),
         .din       (in_byte),
         .load      (1'b0),
         .load_data ('0),
         .col       (bank[c])
      );
      mod_ldr_col u_out (
         .clk       (clk),
         .resetn    (resetn),
         .clear     (1'b0),
         .wr_en     (1'b0),
         .row       (wr_row),
         .din       (in_byte),
         .load      (xfer),
         .load_data (load_blk[c]),
         .col       (out_state[c])
      );
   end
`else
   for (genvar c = 0; c < NC; c++) begin : g_col
      mod_ldr_col u_out (
         .clk       (clk),
         .resetn    (resetn),
         .clear     (1'b0),
         .wr_en     (col_wr_en[c]),
         .row       (wr_row),
         .din       (in_byte),
         .load      (1'b0),
         .load_data ('0),
         .col       (out_state[c])
      );
   end
`endif

   // Loader FSM with slot counter and registered out_valid.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         byte_cnt  <= '0;
         out_valid <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         byte_cnt  <= '0;
         out_valid <= 1'b0;
      end else begin
`ifdef LOADER_DBLBUF_EN
         // Plain hand-off with no replacement block behind it.
         if (out_valid && out_ready && !xfer) begin
            out_valid <= 1'b0;
         end
`endif
         case (state)
            IDLE, FILL: begin
               if (wr) begin
                  if (last) begin
                     byte_cnt <= '0;
`ifdef LOADER_DBLBUF_EN
                     if (xfer) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                     end else begin
                        state <= FULL;
                     end
`else
                     state     <= FULL;
                     out_valid <= 1'b1;
`endif
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                     state    <= FILL;
                  end
               end
            end
            FULL: begin
               if (out_ready) begin
                  state <= IDLE;
`ifdef LOADER_DBLBUF_EN
                  // Consumer took the old block; the waiting bank replaces it.
                  out_valid <= 1'b1;
`else
                  out_valid <= 1'b0;
`endif
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
